// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller response path.
// Holds the response FSM state encoding and the frame command codes.
// The command codes double as tag bytes when SYS_RSP_TAG_EN is defined.
package sys_ctrl_pkg;

  // Response formatter states. TAG is only entered when tagging is built in.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TAG     = 3'd1,
    ST_SEND_LO = 3'd2,
    ST_SEND_HI = 3'd3,
    ST_SEND_RD = 3'd4
  } rsp_state_e;

  // Frame request codes from the host.
  localparam logic [7:0] RF_WR_CMD  = 8'hAA;
  localparam logic [7:0] RF_RD_CMD  = 8'hBB;
  localparam logic [7:0] ALU_WP_CMD = 8'hCC;
  localparam logic [7:0] ALU_NP_CMD = 8'hDD;

endpackage

// File: rtl/sys_rsp_formatter.sv
// Response formatter: serialises register-read bytes and 16-bit ALU results
// into the TX FIFO write port, one byte per cycle.
// Optional feature macro: SYS_RSP_TAG_EN (prefix each response with a tag byte).
//
// Handshake: RD_DATA_VLD / ALU_OUT_VLD are single-cycle pulses accepted only
// when the block is idle (state IDLE and BUSY low). WR_INC is a registered
// strobe; the FIFO takes WR_DATA in every cycle where WR_INC is high. The
// write launched at an edge is suppressed when FIFO_FULL is high at that
// edge, and the same byte is retried at the next edge.
module sys_rsp_formatter
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ALU_OUT_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RD_DATA,
  input  logic                     RD_DATA_VLD,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  input  logic                     FIFO_FULL,
  output logic [DATA_WIDTH-1:0]    WR_DATA,
  output logic                     WR_INC,
  output logic                     BUSY,
  output logic                     OVERRUN,
  output logic [2:0]               dbg_state
);

  rsp_state_e                 state;
  logic [ALU_OUT_WIDTH-1:0]   alu_hold;
  logic [DATA_WIDTH-1:0]      rd_hold;
  logic                       pend_rd;   // read captured alongside an ALU result
  logic                       rsp_alu;   // current response is an ALU result

  logic                       accept;
  logic [ALU_OUT_WIDTH-1:0]   cur_alu;
  logic [DATA_WIDTH-1:0]      cur_rd;
  logic                       cur_is_alu;
  logic                       cur_pend;
  rsp_state_e                 cur_state;
  rsp_state_e                 next_state;
  logic [DATA_WIDTH-1:0]      cur_byte;

  assign dbg_state = state;

  // Resolve the byte to launch this edge; on acceptance the incoming data is
  // used directly so the first byte goes out the cycle after the valid.
  always_comb begin
    accept     = (state == ST_IDLE) && !BUSY && (ALU_OUT_VLD || RD_DATA_VLD);
    cur_alu    = (accept && ALU_OUT_VLD) ? ALU_OUT : alu_hold;
    cur_rd     = (accept && RD_DATA_VLD) ? RD_DATA : rd_hold;
    cur_is_alu = accept ? ALU_OUT_VLD : rsp_alu;
    cur_pend   = accept ? (ALU_OUT_VLD && RD_DATA_VLD) : pend_rd;
    cur_state  = state;
    if (accept) begin
`ifdef SYS_RSP_TAG_EN
      cur_state = ST_TAG;
`else
      cur_state = ALU_OUT_VLD ? ST_SEND_LO : ST_SEND_RD;
`endif
    end

    cur_byte   = '0;
    next_state = ST_IDLE;
    case (cur_state)
`ifdef SYS_RSP_TAG_EN
      ST_TAG: begin
        cur_byte   = cur_is_alu ? DATA_WIDTH'(ALU_WP_CMD) : DATA_WIDTH'(RF_RD_CMD);
        next_state = cur_is_alu ? ST_SEND_LO : ST_SEND_RD;
      end
`endif
      ST_SEND_LO: begin
        cur_byte   = cur_alu[DATA_WIDTH-1:0];
        next_state = ST_SEND_HI;
      end
      ST_SEND_HI: begin
        cur_byte = cur_alu[ALU_OUT_WIDTH-1:DATA_WIDTH];
`ifdef SYS_RSP_TAG_EN
        next_state = cur_pend ? ST_TAG : ST_IDLE;
`else
        next_state = cur_pend ? ST_SEND_RD : ST_IDLE;
`endif
      end
      ST_SEND_RD: begin
        cur_byte   = cur_rd;
        next_state = ST_IDLE;
      end
      default: begin
        cur_byte   = '0;
        next_state = ST_IDLE;
      end
    endcase
  end

  // FSM, holding registers and registered FIFO write port.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= ST_IDLE;
      alu_hold <= '0;
      rd_hold  <= '0;
      pend_rd  <= 1'b0;
      rsp_alu  <= 1'b0;
      WR_DATA  <= '0;
      WR_INC   <= 1'b0;
      BUSY     <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      // Anything arriving while busy is dropped and reported.
      OVERRUN <= BUSY && (ALU_OUT_VLD || RD_DATA_VLD);
      if (accept && ALU_OUT_VLD) alu_hold <= ALU_OUT;
      if (accept && RD_DATA_VLD) rd_hold  <= RD_DATA;

      if (cur_state != ST_IDLE) begin
        BUSY    <= 1'b1;
        WR_DATA <= cur_byte;
        if (!FIFO_FULL) begin
          WR_INC <= 1'b1;
          state  <= next_state;
          // Leaving SEND_HI hands over to the deferred read, if any.
          if (cur_state == ST_SEND_HI) begin
            pend_rd <= 1'b0;
            rsp_alu <= 1'b0;
          end else begin
            pend_rd <= cur_pend;
            rsp_alu <= cur_is_alu;
          end
        end else begin
          WR_INC  <= 1'b0;
          state   <= cur_state;
          pend_rd <= cur_pend;
          rsp_alu <= cur_is_alu;
        end
      end else begin
        WR_INC <= 1'b0;
        BUSY   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sys_rsp_formatter.sv
// Testbench for sys_rsp_formatter: table of single-response vectors plus
// hand-written sequences for stall, overrun, and mid-response reset.
// Expectations follow SYS_RSP_TAG_EN when that macro is defined.
module tb_sys_rsp_formatter;
  import sys_ctrl_pkg::*;

  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] rd_data;
  logic          rd_data_vld;
  logic [AW-1:0] alu_out;
  logic          alu_out_vld;
  logic          fifo_full;
  logic [DW-1:0] wr_data;
  logic          wr_inc;
  logic          busy;
  logic          overrun;
  logic [2:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          alu_vld;
    logic [AW-1:0] alu;
    logic          rd_vld;
    logic [DW-1:0] rd;
    int            n;
    logic [DW-1:0] b [5];
  } vec_t;
  vec_t vecs[$];

  sys_rsp_formatter #(.DATA_WIDTH(DW), .ALU_OUT_WIDTH(AW)) dut (
    .CLK(clk), .RST(rst),
    .RD_DATA(rd_data), .RD_DATA_VLD(rd_data_vld),
    .ALU_OUT(alu_out), .ALU_OUT_VLD(alu_out_vld),
    .FIFO_FULL(fifo_full),
    .WR_DATA(wr_data), .WR_INC(wr_inc), .BUSY(busy), .OVERRUN(overrun),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic av, input logic [AW-1:0] a, input logic rv,
                         input logic [DW-1:0] r, input int n,
                         input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                         input logic [DW-1:0] b2, input logic [DW-1:0] b3,
                         input logic [DW-1:0] b4);
    vec_t v;
    v.alu_vld = av; v.alu = a; v.rd_vld = rv; v.rd = r; v.n = n;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
    vecs.push_back(v);
  endtask

  // driver: assert the valids at the current negedge for one cycle
  task automatic drive(input logic av, input logic [AW-1:0] a, input logic rv, input logic [DW-1:0] r);
    alu_out_vld = av; alu_out = a; rd_data_vld = rv; rd_data = r;
    @(negedge clk);
    alu_out_vld = 1'b0; rd_data_vld = 1'b0;
  endtask

  task automatic push_alu(input logic [AW-1:0] a);
`ifdef SYS_RSP_TAG_EN
    exp_q.push_back(ALU_WP_CMD);
`endif
    exp_q.push_back(a[7:0]);
    exp_q.push_back(a[15:8]);
  endtask

  task automatic push_rd(input logic [DW-1:0] r);
`ifdef SYS_RSP_TAG_EN
    exp_q.push_back(RF_RD_CMD);
`endif
    exp_q.push_back(r);
  endtask

  // scoreboard: current cycle must write the head of exp_q
  task automatic expect_write(input string name);
    logic [DW-1:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check({name, " wr_inc"}, 32'(wr_inc), 32'd1);
    check({name, " wr_data"}, 32'(wr_data), 32'(e));
    check({name, " busy"}, 32'(busy), 32'd1);
  endtask

  task automatic expect_idle(input string name);
    check({name, " wr_inc"}, 32'(wr_inc), 32'd0);
    check({name, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0; rd_data = '0; rd_data_vld = 1'b0; alu_out = '0; alu_out_vld = 1'b0;
    fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    check("reset wr_data", 32'(wr_data), 32'd0);
    check("reset wr_inc", 32'(wr_inc), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // {alu_vld, alu, rd_vld, rd, byte count, bytes in write order}
`ifdef SYS_RSP_TAG_EN
    add_vec(1, 16'h1234, 0, 8'h00, 3, 8'hCC, 8'h34, 8'h12, 8'h00, 8'h00);
    add_vec(0, 16'h0000, 1, 8'h5A, 2, 8'hBB, 8'h5A, 8'h00, 8'h00, 8'h00);
    add_vec(1, 16'h00FF, 1, 8'h77, 5, 8'hCC, 8'hFF, 8'h00, 8'hBB, 8'h77);
    add_vec(1, 16'hFFFF, 0, 8'h00, 3, 8'hCC, 8'hFF, 8'hFF, 8'h00, 8'h00);
    add_vec(0, 16'h0000, 1, 8'h00, 2, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00);
    add_vec(1, 16'h8001, 1, 8'hC3, 5, 8'hCC, 8'h01, 8'h80, 8'hBB, 8'hC3);
`else
    add_vec(1, 16'h1234, 0, 8'h00, 2, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00);
    add_vec(0, 16'h0000, 1, 8'h5A, 1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00);
    add_vec(1, 16'h00FF, 1, 8'h77, 3, 8'hFF, 8'h00, 8'h77, 8'h00, 8'h00);
    add_vec(1, 16'hFFFF, 0, 8'h00, 2, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
    add_vec(0, 16'h0000, 1, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    add_vec(1, 16'h8001, 1, 8'hC3, 3, 8'h01, 8'h80, 8'hC3, 8'h00, 8'h00);
`endif

    // Back-to-back: each new valid lands in the first cycle with BUSY low.
    foreach (vecs[i]) begin
      drive(vecs[i].alu_vld, vecs[i].alu, vecs[i].rd_vld, vecs[i].rd);
      for (int k = 0; k < vecs[i].n; k++) exp_q.push_back(vecs[i].b[k]);
      for (int k = 0; k < vecs[i].n; k++) begin
        expect_write($sformatf("vec%0d byte%0d", i, k));
        check($sformatf("vec%0d overrun%0d", i, k), 32'(overrun), 32'd0);
        if (k < vecs[i].n - 1) @(negedge clk);
      end
      @(negedge clk);
      expect_idle($sformatf("vec%0d idle", i));
    end

    // FIFO_FULL for 3 cycles after the first byte: next byte held, then written.
    drive(1, 16'hABCD, 0, 8'h00);
    push_alu(16'hABCD);
    expect_write("stall first");
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d wr_inc", i), 32'(wr_inc), 32'd0);
      check($sformatf("stall%0d wr_data", i), 32'(wr_data), 32'(exp_q[0]));
      check($sformatf("stall%0d busy", i), 32'(busy), 32'd1);
      if (i == 2) fifo_full = 1'b0;
    end
    while (exp_q.size() != 0) begin
      @(negedge clk);
      expect_write("stall resume");
    end
    @(negedge clk);
    expect_idle("stall idle");

    // Read valid while busy: dropped, OVERRUN next cycle, stream unchanged.
    drive(1, 16'h1234, 0, 8'h00);
    push_alu(16'h1234);
    expect_write("ovr byte0");
    rd_data_vld = 1'b1; rd_data = 8'h99;
    @(negedge clk);
    rd_data_vld = 1'b0;
    check("ovr pulse", 32'(overrun), 32'd1);
    expect_write("ovr byte1");
    while (exp_q.size() != 0) begin
      @(negedge clk);
      check("ovr single", 32'(overrun), 32'd0);
      expect_write("ovr rest");
    end
    @(negedge clk);
    expect_idle("ovr idle");
    check("ovr clear", 32'(overrun), 32'd0);
    @(negedge clk);
    check("ovr no extra", 32'(wr_inc), 32'd0);

    // Valid in the cycle of the last write is still dropped.
    drive(0, 16'h0000, 1, 8'h5A);
    push_rd(8'h5A);
    while (exp_q.size() > 1) begin
      expect_write("last pre");
      @(negedge clk);
    end
    expect_write("last byte");
    alu_out_vld = 1'b1; alu_out = 16'hBEEF;
    @(negedge clk);
    alu_out_vld = 1'b0;
    check("last overrun", 32'(overrun), 32'd1);
    expect_idle("last idle");
    @(negedge clk);
    check("last no write", 32'(wr_inc), 32'd0);

    // Reset between LSB and MSB of an ALU response.
    drive(1, 16'h1234, 0, 8'h00);
    push_alu(16'h1234);
`ifdef SYS_RSP_TAG_EN
    expect_write("rst tag");
    @(negedge clk);
`endif
    expect_write("rst lsb");
    rst = 1'b0;
    @(negedge clk);
    check("rst wr_data", 32'(wr_data), 32'd0);
    check("rst wr_inc", 32'(wr_inc), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    expect_idle("rst after");
    drive(0, 16'h0000, 1, 8'h11);
    push_rd(8'h11);
    while (exp_q.size() != 0) begin
      expect_write("rst rd");
      @(negedge clk);
    end
    expect_idle("rst rd idle");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("rst quiet%0d", i), 32'(wr_inc), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
